// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte-stream loader writing program memory, holding the CPU until a good checksum
module prog_loader #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          mem_wren,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_data,
  output logic          cpu_hold,
  output logic          done,
  output logic          error
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    BASE = 3'd1,
    LEN  = 3'd2,
    DATA = 3'd3,
    CSUM = 3'd4,
    DONE = 3'd5,
    ERR  = 3'd6
  } state_t;

  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
  localparam logic [AW:0]   COUNT_ONE = (AW + 1)'(1);

  state_t        state;
  state_t        state_next;
  logic [AW-1:0] addr;
  logic [AW:0]   count;
  logic [DW-1:0] sum;
  logic [DW-1:0] sum_total;
  logic [AW:0]   len_value;
  logic          take;

  // start outranks a byte presented on the same edge, so that byte is dropped
  assign take      = in_valid && in_ready && !start;
  assign sum_total = sum + in_data;

  always_comb begin
    len_value = {1'b0, in_data[AW-1:0]};
    if (in_data[AW-1:0] == '0) begin
      len_value[AW] = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    cpu_hold   = 1'b1;
    done       = 1'b0;
    error      = 1'b0;
    case (state)
      IDLE: ;
      BASE: begin
        in_ready = 1'b1;
        if (take) state_next = LEN;
      end
      LEN: begin
        in_ready = 1'b1;
        if (take) state_next = DATA;
      end
      DATA: begin
        in_ready = 1'b1;
        if (take && count == COUNT_ONE) state_next = CSUM;
      end
      CSUM: begin
        in_ready = 1'b1;
        if (take) state_next = (sum_total == '0) ? DONE : ERR;
      end
      DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
      end
      ERR: begin
        error = 1'b1;
      end
      default: state_next = IDLE;
    endcase
    if (start) begin
      state_next = BASE;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_wren    <= 1'b0;
      mem_address <= '0;
      mem_data    <= '0;
      addr        <= '0;
      count       <= '0;
      sum         <= '0;
    end else begin
      mem_wren <= 1'b0;
      if (take) begin
        case (state)
          BASE: addr <= in_data[AW-1:0];
          LEN: begin
            count <= len_value;
            sum   <= '0;
          end
          DATA: begin
            mem_wren    <= 1'b1;
            mem_address <= addr;
            mem_data    <= in_data;
            addr        <= addr + ADDR_ONE;
            sum         <= sum_total;
            count       <= count - COUNT_ONE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
